// File: rtl/mem_bus_controller_pkg.sv
// mem_bus_controller_pkg: shared FSM encoding, counter width and timing defaults for the SRAM bus controller
package mem_bus_controller_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int CNT_W = 4;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES = 1;
  localparam int DEF_MEM_DEPTH = 2048;
endpackage

// File: rtl/mem_bus_controller_phase_counter.sv
// mem_bus_controller_phase_counter: per-phase down counter that flags the last cycle of a phase
module mem_bus_controller_phase_counter
  import mem_bus_controller_pkg::*;
(
  input  logic clk,
  input  logic nreset,
  input  logic load,
  input  logic [CNT_W-1:0] load_value,
  output logic last
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) count <= '0;
    else count <= load ? load_value : count - CNT_W'(count != '0);
  assign last = count == CNT_W'(1);
endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: registered SRAM master with SETUP/STROBE/HOLD timing; MEMCTL_BOUNDS_CHECK_EN rejects addresses >= MEM_DEPTH
module mem_bus_controller
  import mem_bus_controller_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
`ifdef MEMCTL_BOUNDS_CHECK_EN
  , parameter int MEM_DEPTH = DEF_MEM_DEPTH
`endif
) (
  input  logic clk,
  input  logic nreset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [11:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic rsp_error,
  output logic [11:0] address,
  inout  wire [7:0] data_bus,
  output logic nchip_enable,
  output logic nwrite_enable,
  output logic nread_enable
);
  state_t state;
  logic write_q, drive, last, oob, accept;
  logic [7:0] wdata_q;
`ifdef MEMCTL_BOUNDS_CHECK_EN
  assign oob = {20'd0, req_addr} >= 32'(MEM_DEPTH);
`else
  assign oob = 1'b0;
`endif
  assign accept = req_valid && req_ready;
  assign data_bus = drive ? wdata_q : 8'bz;
  mem_bus_controller_phase_counter u_phase (
    .clk(clk),
    .nreset(nreset),
    .load(accept && !oob || state != IDLE && last),
    .load_value(state == IDLE ? CNT_W'(SETUP_CYCLES) : state == SETUP ? CNT_W'(STROBE_CYCLES) : CNT_W'(HOLD_CYCLES)),
    .last(last)
  );
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      address <= '0;
      nchip_enable <= 1'b1;
      nwrite_enable <= 1'b1;
      nread_enable <= 1'b1;
      drive <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      case (state)
        IDLE:
          if (accept && oob) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
          end else if (accept) begin
            state <= SETUP;
            req_ready <= 1'b0;
            nchip_enable <= 1'b0;
            address <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            drive <= req_write;
          end
        SETUP:
          if (last) begin
            state <= STROBE;
            nread_enable <= write_q;
            nwrite_enable <= !write_q;
          end
        STROBE:
          if (last) begin
            state <= HOLD;
            nread_enable <= 1'b1;
            nwrite_enable <= 1'b1;
            if (!write_q) rsp_rdata <= data_bus;
          end
        HOLD:
          if (last) begin
            state <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            nchip_enable <= 1'b1;
            drive <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: scoreboard bench with behavioural SRAMs behind a default and a S=3,T=1,H=2 controller
module tb_mem_bus_controller;
  logic clk = 1'b0, nreset = 1'b0, req_valid = 1'b0, req_write = 1'b0, use2 = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic ready1, rspv1, err1, nce1, nwe1, nre1, ready2, rspv2, err2, nce2, nwe2, nre2;
  logic [7:0] rdata1, rdata2;
  logic [11:0] addr1, addr2;
  wire [7:0] bus1, bus2;
  int cyc = 0, tests = 0, failed = 0;
  logic [7:0] mem1 [4096];
  logic [7:0] mem2 [4096];

  typedef struct { logic rd; logic [7:0] rdata; logic err; int lat; } exp_t;
  typedef struct { int lat, acc, nce, nwe, nre, drv, dval; logic overlap, err, ok; logic [11:0] addr; logic [7:0] rdata; } obs_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_controller dut1 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid && !use2), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv1), .rsp_rdata(rdata1), .rsp_error(err1), .address(addr1),
    .data_bus(bus1), .nchip_enable(nce1), .nwrite_enable(nwe1), .nread_enable(nre1)
  );
  mem_bus_controller #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid && use2), .req_ready(ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv2), .rsp_rdata(rdata2), .rsp_error(err2), .address(addr2),
    .data_bus(bus2), .nchip_enable(nce2), .nwrite_enable(nwe2), .nread_enable(nre2)
  );

  pullup (bus1);
  pullup (bus2);
  assign bus1 = (!nce1 && !nre1) ? mem1[addr1] : 8'bz;
  assign bus2 = (!nce2 && !nre2) ? mem2[addr2] : 8'bz;
  always @(posedge nwe1) if (!nce1) mem1[addr1] <= bus1;
  always @(posedge nwe2) if (!nce2) mem2[addr2] <= bus2;

  wire m_ready = use2 ? ready2 : ready1;
  wire m_rsp = use2 ? rspv2 : rspv1;
  wire m_err = use2 ? err2 : err1;
  wire m_nce = use2 ? nce2 : nce1;
  wire m_nwe = use2 ? nwe2 : nwe1;
  wire m_nre = use2 ? nre2 : nre1;
  wire [7:0] m_rdata = use2 ? rdata2 : rdata1;
  wire [11:0] m_addr = use2 ? addr2 : addr1;
  wire [7:0] m_bus = use2 ? bus2 : bus1;

  task automatic access(input logic wr, input logic [11:0] a, input logic [7:0] d, input logic keep, output obs_t o);
    int n = 0;
    o = '{default: 0};
    req_write = wr;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    o.acc = cyc;
    for (int i = 0; i < 50 && !o.ok; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!keep) req_valid = 1'b0;
        req_write = ~wr;
        req_addr = ~a;
        req_wdata = ~d;
      end
      if (!m_nce) begin
        o.nce++;
        o.addr = m_addr;
      end
      if (!m_nwe) o.nwe++;
      if (!m_nre) o.nre++;
      if (!m_nwe && !m_nre) o.overlap = 1'b1;
      if (m_nre && m_bus !== 8'hFF) o.drv++;
      if (m_bus === d) o.dval++;
      if (m_rsp) begin
        o.ok = 1'b1;
        o.lat = cyc - o.acc;
        o.rdata = m_rdata;
        o.err = m_err;
      end
    end
    tests++;
    if (!o.ok) begin
      failed++;
      $display("FAIL rsp_timeout addr=%h: no rsp_valid within 50 cycles", a);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    tests++;
    if ({nce1, nwe1, nre1, ready1, rspv1, err1} !== 6'b111100) begin
      failed++;
      $display("FAIL reset_ctl got %b want 111100", {nce1, nwe1, nre1, ready1, rspv1, err1});
    end
    tests++;
    if (addr1 !== 12'h000 || rdata1 !== 8'h00) begin
      failed++;
      $display("FAIL reset_regs addr=%h rdata=%h want 000/00", addr1, rdata1);
    end
    tests++;
    if (bus1 !== 8'hFF || bus2 !== 8'hFF) begin
      failed++;
      $display("FAIL reset_bus got %h/%h want released (FF)", bus1, bus2);
    end
    tests++;
    if ({nce2, nwe2, nre2, ready2, rspv2} !== 5'b11110) begin
      failed++;
      $display("FAIL reset_ctl2 got %b want 11110", {nce2, nwe2, nre2, ready2, rspv2});
    end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    obs_t o;
    exp_t e;
    sb.push_back('{rd: 1'b0, rdata: 8'h00, err: 1'b0, lat: 5});
    access(1'b1, 12'h123, 8'hA5, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.lat !== e.lat || o.err !== e.err) begin
      failed++;
      $display("FAIL write_rsp lat=%0d err=%b want %0d/%b", o.lat, o.err, e.lat, e.err);
    end
    tests++;
    if (o.nwe !== 2 || o.nre !== 0 || o.nce !== 4) begin
      failed++;
      $display("FAIL write_strobes nwe=%0d nre=%0d nce=%0d want 2/0/4", o.nwe, o.nre, o.nce);
    end
    tests++;
    if (o.dval !== 4 || o.drv !== 4) begin
      failed++;
      $display("FAIL write_drive a5_cycles=%0d driven=%0d want 4/4", o.dval, o.drv);
    end
    tests++;
    if (mem1[12'h123] !== 8'hA5 || o.addr !== 12'h123) begin
      failed++;
      $display("FAIL write_ram ram=%h addr=%h want a5/123", mem1[12'h123], o.addr);
    end
  endtask

  task automatic test_read;
    obs_t o;
    exp_t e;
    sb.push_back('{rd: 1'b1, rdata: 8'hA5, err: 1'b0, lat: 5});
    access(1'b0, 12'h123, 8'h00, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.rdata !== e.rdata || o.lat !== e.lat || o.err !== e.err) begin
      failed++;
      $display("FAIL read_rsp rdata=%h lat=%0d err=%b want %h/%0d/%b", o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
    end
    tests++;
    if (o.nre !== 2 || o.nwe !== 0 || o.drv !== 0 || o.overlap) begin
      failed++;
      $display("FAIL read_strobes nre=%0d nwe=%0d master_drive=%0d overlap=%b want 2/0/0/0", o.nre, o.nwe, o.drv, o.overlap);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2;
    exp_t e;
    sb.push_back('{rd: 1'b0, rdata: 8'h00, err: 1'b0, lat: 5});
    sb.push_back('{rd: 1'b1, rdata: 8'h3C, err: 1'b0, lat: 5});
    access(1'b1, 12'h7FF, 8'h3C, 1'b1, o1);
    access(1'b0, 12'h7FF, 8'h00, 1'b0, o2);
    e = sb.pop_front();
    tests++;
    if (o1.lat !== e.lat) begin
      failed++;
      $display("FAIL b2b_write_lat got %0d want %0d", o1.lat, e.lat);
    end
    e = sb.pop_front();
    tests++;
    if (o2.rdata !== e.rdata || o2.lat !== e.lat) begin
      failed++;
      $display("FAIL b2b_read rdata=%h lat=%0d want %h/%0d", o2.rdata, o2.lat, e.rdata, e.lat);
    end
    tests++;
    if (o2.acc - o1.acc !== 5) begin
      failed++;
      $display("FAIL b2b_accept_gap got %0d want 5", o2.acc - o1.acc);
    end
    tests++;
    if (o1.overlap || o2.overlap) begin
      failed++;
      $display("FAIL b2b_overlap got %b%b want 00", o1.overlap, o2.overlap);
    end
  endtask

  task automatic test_params;
    obs_t o;
    exp_t e;
    use2 = 1'b1;
    sb.push_back('{rd: 1'b0, rdata: 8'h00, err: 1'b0, lat: 7});
    sb.push_back('{rd: 1'b1, rdata: 8'h96, err: 1'b0, lat: 7});
    access(1'b1, 12'h010, 8'h96, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.lat !== e.lat || o.nwe !== 1 || o.nce !== 6 || o.dval !== 6) begin
      failed++;
      $display("FAIL param_write lat=%0d nwe=%0d nce=%0d drive=%0d want %0d/1/6/6", o.lat, o.nwe, o.nce, o.dval, e.lat);
    end
    access(1'b0, 12'h010, 8'h00, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.lat !== e.lat || o.rdata !== e.rdata || o.nre !== 1 || o.nce !== 6) begin
      failed++;
      $display("FAIL param_read lat=%0d rdata=%h nre=%0d nce=%0d want %0d/%h/1/6", o.lat, o.rdata, o.nre, o.nce, e.lat, e.rdata);
    end
    use2 = 1'b0;
  endtask

  task automatic test_bounds;
    obs_t o;
    exp_t e;
`ifdef MEMCTL_BOUNDS_CHECK_EN
    sb.push_back('{rd: 1'b1, rdata: 8'h3C, err: 1'b1, lat: 1});
    access(1'b0, 12'h800, 8'h00, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.err !== e.err || o.lat !== e.lat || o.rdata !== e.rdata) begin
      failed++;
      $display("FAIL bounds_rsp err=%b lat=%0d rdata=%h want %b/%0d/%h", o.err, o.lat, o.rdata, e.err, e.lat, e.rdata);
    end
    tests++;
    if (o.nce !== 0 || o.nre !== 0 || o.nwe !== 0) begin
      failed++;
      $display("FAIL bounds_strobes nce=%0d nre=%0d nwe=%0d want 0/0/0", o.nce, o.nre, o.nwe);
    end
`else
    sb.push_back('{rd: 1'b0, rdata: 8'h00, err: 1'b0, lat: 5});
    sb.push_back('{rd: 1'b1, rdata: 8'h5E, err: 1'b0, lat: 5});
    access(1'b1, 12'h800, 8'h5E, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.lat !== e.lat || o.err !== e.err) begin
      failed++;
      $display("FAIL nobounds_write lat=%0d err=%b want %0d/%b", o.lat, o.err, e.lat, e.err);
    end
    access(1'b0, 12'h800, 8'h00, 1'b0, o);
    e = sb.pop_front();
    tests++;
    if (o.err !== e.err || o.rdata !== e.rdata || o.lat !== e.lat) begin
      failed++;
      $display("FAIL nobounds_read err=%b rdata=%h lat=%0d want %b/%h/%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
    end
    tests++;
    if (o.addr !== 12'h800 || o.nce !== 4) begin
      failed++;
      $display("FAIL nobounds_addr addr=%h nce=%0d want 800/4", o.addr, o.nce);
    end
`endif
  endtask

  task automatic test_reset_abort;
    int n = 0, seen = 0;
    req_write = 1'b1;
    req_addr = 12'h040;
    req_wdata = 8'h55;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (nwe1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (nwe1 !== 1'b0) begin
      failed++;
      $display("FAIL abort_reach_strobe nwe=%b want 0", nwe1);
    end
    #1 nreset = 1'b0;
    #1;
    tests++;
    if ({nce1, nwe1, nre1, rspv1} !== 4'b1110) begin
      failed++;
      $display("FAIL abort_strobes got %b want 1110", {nce1, nwe1, nre1, rspv1});
    end
    tests++;
    if (bus1 !== 8'hFF) begin
      failed++;
      $display("FAIL abort_bus got %h want released (FF)", bus1);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rspv1) seen++;
    end
    tests++;
    if (seen !== 0 || ready1 !== 1'b1) begin
      failed++;
      $display("FAIL abort_no_rsp rsp_count=%0d ready=%b want 0/1", seen, ready1);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_params;
    test_bounds;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
